// File: rtl/load_store_unit_if.sv
// Bundles the execute-stage request/response channels and the data-memory
// port of the load/store unit. The master side is the execute stage plus the
// memory. The slave side is the load/store unit itself.
interface load_store_unit_if;
  // request channel
  logic        reqValid;
  logic        reqReady;
  logic [3:0]  reqOp;
  logic [31:0] reqAddress;
  logic [31:0] reqData;
  // response channel
  logic        respValid;
  logic        respReady;
  logic [31:0] respData;
  logic        respError;
  // memory port
  logic [31:0] memAddress;
  logic [31:0] memData;
  logic [2:0]  memWriteMode;
  logic [2:0]  memReadMode;
  logic        memUnsignedLoad;
  logic [31:0] memDataIn;

  modport master (
    output reqValid, reqOp, reqAddress, reqData, respReady, memDataIn,
    input  reqReady, respValid, respData, respError,
           memAddress, memData, memWriteMode, memReadMode, memUnsignedLoad
  );

  modport slave (
    input  reqValid, reqOp, reqAddress, reqData, respReady, memDataIn,
    output reqReady, respValid, respData, respError,
           memAddress, memData, memWriteMode, memReadMode, memUnsignedLoad
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port. It takes one
// load/store at a time, checks legality and alignment, drives the memory
// modes for the access, and merges LWL/LWR results with the old rt value.
// Every output comes straight from a register.
module load_store_unit #(
  parameter int unsigned LOAD_WAIT   = 32'd0,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_BYTE  = 3'd1;
  localparam logic [2:0] MODE_HALF  = 3'd2;
  localparam logic [2:0] MODE_WORD  = 3'd3;
  localparam logic [2:0] MODE_LEFT  = 3'd4;
  localparam logic [2:0] MODE_RIGHT = 3'd5;

  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;

  // index of the last load cycle on the memory port
  localparam logic [3:0] WAIT_LAST = 4'(LOAD_WAIT);

  // Memory mode for an op. NONE marks an illegal op.
  function automatic logic [2:0] op_mode(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd8: op_mode = MODE_BYTE;
      4'd2, 4'd3, 4'd9: op_mode = MODE_HALF;
      4'd4, 4'd10:      op_mode = MODE_WORD;
      4'd5, 4'd11:      op_mode = MODE_LEFT;
      4'd6, 4'd12:      op_mode = MODE_RIGHT;
      default:          op_mode = MODE_NONE;
    endcase
  endfunction

  // Halfword ops need addr[0]==0. Full-word ops need addr[1:0]==0.
  // The unaligned-word ops LWL/LWR/SWL/SWR are never misaligned.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      4'd2, 4'd3, 4'd9: misaligned = a[0];
      4'd4, 4'd10:      misaligned = (a != 2'd0);
      default:          misaligned = 1'b0;
    endcase
  endfunction

  // Keep the rt bytes that the memory word does not overwrite.
  function automatic logic [31:0] merge_load(input logic [3:0] op, input logic [1:0] k,
                                             input logic [31:0] mem, input logic [31:0] rt);
    logic [31:0] m;
    case (op)
      OP_LWL: begin
        case (k)
          2'd0:    m = 32'h00FF_FFFF;
          2'd1:    m = 32'h0000_FFFF;
          2'd2:    m = 32'h0000_00FF;
          default: m = 32'h0000_0000;
        endcase
      end
      OP_LWR: begin
        case (k)
          2'd0:    m = 32'h0000_0000;
          2'd1:    m = 32'hFF00_0000;
          2'd2:    m = 32'hFFFF_0000;
          default: m = 32'hFFFF_FF00;
        endcase
      end
      default: m = 32'h0000_0000;
    endcase
    merge_load = mem | (rt & m);
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  op_r, op_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        ready_r, ready_s;
  logic        resp_valid_r, resp_valid_s;
  logic [31:0] resp_data_r, resp_data_s;
  logic        resp_error_r, resp_error_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [31:0] mem_data_r, mem_data_s;
  logic [2:0]  wmode_r, wmode_s;
  logic [2:0]  rmode_r, rmode_s;
  logic        uload_r, uload_s;

  // Next state and next register values for every output
  always_comb begin
    state_s      = state_r;
    op_s         = op_r;
    cnt_s        = cnt_r;
    resp_valid_s = resp_valid_r;
    resp_data_s  = resp_data_r;
    resp_error_s = resp_error_r;
    mem_addr_s   = mem_addr_r;
    mem_data_s   = mem_data_r;
    wmode_s      = wmode_r;
    rmode_s      = rmode_r;
    uload_s      = uload_r;
    case (state_r)
      IDLE: begin
        if (bus.reqValid) begin
          op_s       = bus.reqOp;
          mem_addr_s = bus.reqAddress;
          mem_data_s = bus.reqData;
          cnt_s      = 4'd0;
          if ((op_mode(bus.reqOp) == MODE_NONE) ||
              (CHECK_ALIGN && misaligned(bus.reqOp, bus.reqAddress[1:0]))) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_data_s  = 32'd0;
            resp_error_s = 1'b1;
          end else begin
            state_s      = ACCESS;
            resp_data_s  = 32'd0;
            resp_error_s = 1'b0;
            uload_s      = (bus.reqOp == OP_LBU) || (bus.reqOp == OP_LHU);
            if (bus.reqOp[3]) begin
              wmode_s = op_mode(bus.reqOp);
            end else begin
              rmode_s = op_mode(bus.reqOp);
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (op_r[3]) begin
          // a store holds its write mode for this single cycle
          wmode_s      = MODE_NONE;
          uload_s      = 1'b0;
          resp_valid_s = 1'b1;
          resp_data_s  = 32'd0;
          state_s      = RESP;
        end else if (cnt_r == WAIT_LAST) begin
          rmode_s      = MODE_NONE;
          uload_s      = 1'b0;
          resp_valid_s = 1'b1;
          resp_data_s  = merge_load(op_r, mem_addr_r[1:0], bus.memDataIn, mem_data_r);
          state_s      = RESP;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      RESP: begin
        if (bus.respReady) begin
          resp_valid_s = 1'b0;
          state_s      = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s      = IDLE;
        resp_valid_s = 1'b0;
        wmode_s      = MODE_NONE;
        rmode_s      = MODE_NONE;
        uload_s      = 1'b0;
      end
    endcase
    ready_s = (state_s == IDLE);
  end

  // State and output registers. Reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      op_r         <= 4'd0;
      cnt_r        <= 4'd0;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
      resp_error_r <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_data_r   <= 32'd0;
      wmode_r      <= MODE_NONE;
      rmode_r      <= MODE_NONE;
      uload_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      op_r         <= op_s;
      cnt_r        <= cnt_s;
      ready_r      <= ready_s;
      resp_valid_r <= resp_valid_s;
      resp_data_r  <= resp_data_s;
      resp_error_r <= resp_error_s;
      mem_addr_r   <= mem_addr_s;
      mem_data_r   <= mem_data_s;
      wmode_r      <= wmode_s;
      rmode_r      <= rmode_s;
      uload_r      <= uload_s;
    end
  end

  assign bus.reqReady        = ready_r;
  assign bus.respValid       = resp_valid_r;
  assign bus.respData        = resp_data_r;
  assign bus.respError       = resp_error_r;
  assign bus.memAddress      = mem_addr_r;
  assign bus.memData         = mem_data_r;
  assign bus.memWriteMode    = wmode_r;
  assign bus.memReadMode     = rmode_r;
  assign bus.memUnsignedLoad = uload_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. dut0 has LOAD_WAIT=0 and carries
// most scenarios. dut1 has LOAD_WAIT=4 and covers wait latency and reset
// during an access. The bench plays both the execute stage and the memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  load_store_unit_if bus0 ();
  load_store_unit_if bus1 ();

  load_store_unit #(.LOAD_WAIT(0), .CHECK_ALIGN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  load_store_unit #(.LOAD_WAIT(4), .CHECK_ALIGN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    bus0.reqValid   = 1'b1;
    bus0.reqOp      = op;
    bus0.reqAddress = addr;
    bus0.reqData    = data;
    tick();
    bus0.reqValid   = 1'b0;
  endtask

  task automatic send1(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    bus1.reqValid   = 1'b1;
    bus1.reqOp      = op;
    bus1.reqAddress = addr;
    bus1.reqData    = data;
    tick();
    bus1.reqValid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus0.respValid, bus0.respError, bus0.memUnsignedLoad, bus0.memWriteMode, bus0.memReadMode} !== 9'd0)
      $display("FAIL reset_ctrl: got %b expected 0", {bus0.respValid, bus0.respError,
               bus0.memUnsignedLoad, bus0.memWriteMode, bus0.memReadMode});
    checks++;
    if ({bus0.respData, bus0.memAddress, bus0.memData} !== 96'd0)
      $display("FAIL reset_data: got %h expected 0", {bus0.respData, bus0.memAddress, bus0.memData});
    checks++;
    if (bus0.reqReady !== 1'b1)
      $display("FAIL reset_ready: got %b expected 1", bus0.reqReady);
    errors += ((bus0.respValid | bus0.respError | bus0.memUnsignedLoad) !== 1'b0 ||
               {bus0.memWriteMode, bus0.memReadMode} !== 6'd0) ? 1 : 0;
    errors += ({bus0.respData, bus0.memAddress, bus0.memData} !== 96'd0) ? 1 : 0;
    errors += (bus0.reqReady !== 1'b1) ? 1 : 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    bus0.memDataIn = 32'hDEAD_BEEF;
    send0(4'd4, 32'h0000_0100, 32'h0);
    checks++;
    if ({bus0.memReadMode, bus0.memWriteMode, bus0.memAddress} !== {3'd3, 3'd0, 32'h0000_0100}) begin
      errors++;
      $display("FAIL lw_access: rmode=%0d wmode=%0d addr=%h expected 3 0 00000100",
               bus0.memReadMode, bus0.memWriteMode, bus0.memAddress);
    end
    checks++;
    if ({bus0.respValid, bus0.reqReady} !== 2'b00) begin
      errors++;
      $display("FAIL lw_busy: valid/ready=%b expected 00", {bus0.respValid, bus0.reqReady});
    end
    tick();
    checks++;
    if ({bus0.respValid, bus0.respError, bus0.respData, bus0.memReadMode} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 3'd0}) begin
      errors++;
      $display("FAIL lw_resp: valid=%b err=%b data=%h rmode=%0d expected 1 0 deadbeef 0",
               bus0.respValid, bus0.respError, bus0.respData, bus0.memReadMode);
    end
    tick();
    checks++;
    if ({bus0.respValid, bus0.reqReady} !== 2'b01) begin
      errors++;
      $display("FAIL lw_done: valid/ready=%b expected 01", {bus0.respValid, bus0.reqReady});
    end
  endtask

  task automatic test_load_merge();
    logic [3:0]  op_t   [7];
    logic [31:0] addr_t [7];
    logic [31:0] rt_t   [7];
    logic [31:0] mem_t  [7];
    logic [2:0]  mode_t [7];
    logic        ul_t   [7];
    logic [31:0] exp_t  [7];
    op_t   = '{4'd5, 4'd6, 4'd5, 4'd6, 4'd0, 4'd3, 4'd5};
    addr_t = '{32'h102, 32'h101, 32'h100, 32'h103, 32'h007, 32'h006, 32'h103};
    rt_t   = '{32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344, 32'h0, 32'hFFFFFFFF, 32'h11223344};
    mem_t  = '{32'hAABBCC00, 32'h00AABBCC, 32'hAA000000, 32'h000000AA, 32'hFFFFFF80, 32'h0000BEEF, 32'hCC000000};
    mode_t = '{3'd4, 3'd5, 3'd4, 3'd5, 3'd1, 3'd2, 3'd4};
    ul_t   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t  = '{32'hAABBCC44, 32'h11AABBCC, 32'hAA223344, 32'h112233AA, 32'hFFFFFF80, 32'h0000BEEF, 32'hCC000000};
    for (int i = 0; i < 7; i++) begin
      bus0.memDataIn = mem_t[i];
      send0(op_t[i], addr_t[i], rt_t[i]);
      checks++;
      if ({bus0.memReadMode, bus0.memWriteMode, bus0.memUnsignedLoad, bus0.memAddress} !==
          {mode_t[i], 3'd0, ul_t[i], addr_t[i]}) begin
        errors++;
        $display("FAIL load_access[%0d]: rmode=%0d wmode=%0d ul=%b addr=%h expected %0d 0 %b %h", i,
                 bus0.memReadMode, bus0.memWriteMode, bus0.memUnsignedLoad, bus0.memAddress,
                 mode_t[i], ul_t[i], addr_t[i]);
      end
      tick();
      checks++;
      if ({bus0.respValid, bus0.respError, bus0.respData} !== {1'b1, 1'b0, exp_t[i]}) begin
        errors++;
        $display("FAIL load_resp[%0d]: valid=%b err=%b data=%h expected 1 0 %h", i,
                 bus0.respValid, bus0.respError, bus0.respData, exp_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic [3:0]  op_t   [5];
    logic [31:0] addr_t [5];
    logic [31:0] dat_t  [5];
    logic [2:0]  mode_t [5];
    op_t   = '{4'd9, 4'd8, 4'd10, 4'd11, 4'd12};
    addr_t = '{32'h200, 32'h203, 32'h204, 32'h205, 32'h206};
    dat_t  = '{32'h1234ABCD, 32'h000000EE, 32'hCAFEF00D, 32'h01020304, 32'hA5A55A5A};
    mode_t = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd5};
    bus0.memDataIn = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus0.memWriteMode !== 3'd0) begin
        errors++;
        $display("FAIL store_pre[%0d]: wmode=%0d expected 0", i, bus0.memWriteMode);
      end
      send0(op_t[i], addr_t[i], dat_t[i]);
      checks++;
      if ({bus0.memWriteMode, bus0.memReadMode, bus0.memData, bus0.memAddress} !==
          {mode_t[i], 3'd0, dat_t[i], addr_t[i]}) begin
        errors++;
        $display("FAIL store_access[%0d]: wmode=%0d rmode=%0d data=%h addr=%h expected %0d 0 %h %h", i,
                 bus0.memWriteMode, bus0.memReadMode, bus0.memData, bus0.memAddress,
                 mode_t[i], dat_t[i], addr_t[i]);
      end
      tick();
      checks++;
      if ({bus0.memWriteMode, bus0.respValid, bus0.respError, bus0.respData} !== {3'd0, 1'b1, 1'b0, 32'd0}) begin
        errors++;
        $display("FAIL store_resp[%0d]: wmode=%0d valid=%b err=%b data=%h expected 0 1 0 0", i,
                 bus0.memWriteMode, bus0.respValid, bus0.respError, bus0.respData);
      end
      tick();
    end
  endtask

  task automatic test_errors();
    logic [3:0]  op_t   [6];
    logic [31:0] addr_t [6];
    op_t   = '{4'd10, 4'd7, 4'd2, 4'd4, 4'd9, 4'd15};
    addr_t = '{32'h102, 32'h000, 32'h101, 32'h103, 32'h001, 32'h100};
    bus0.memDataIn = 32'h1357_9BDF;
    for (int i = 0; i < 6; i++) begin
      send0(op_t[i], addr_t[i], 32'h5555_AAAA);
      checks++;
      if ({bus0.respValid, bus0.respError, bus0.respData, bus0.memWriteMode, bus0.memReadMode} !==
          {1'b1, 1'b1, 32'd0, 3'd0, 3'd0}) begin
        errors++;
        $display("FAIL err_resp[%0d]: valid=%b err=%b data=%h wmode=%0d rmode=%0d expected 1 1 0 0 0", i,
                 bus0.respValid, bus0.respError, bus0.respData, bus0.memWriteMode, bus0.memReadMode);
      end
      tick();
      checks++;
      if ({bus0.respValid, bus0.reqReady, bus0.memWriteMode, bus0.memReadMode} !== {1'b0, 1'b1, 6'd0}) begin
        errors++;
        $display("FAIL err_done[%0d]: valid=%b ready=%b wmode=%0d rmode=%0d expected 0 1 0 0", i,
                 bus0.respValid, bus0.reqReady, bus0.memWriteMode, bus0.memReadMode);
      end
    end
  endtask

  task automatic test_backpressure();
    bus0.respReady = 1'b0;
    bus0.memDataIn = 32'h0000_00AB;
    send0(4'd1, 32'h0000_0033, 32'h0);
    checks++;
    if ({bus0.memReadMode, bus0.memUnsignedLoad} !== {3'd1, 1'b1}) begin
      errors++;
      $display("FAIL lbu_access: rmode=%0d ul=%b expected 1 1", bus0.memReadMode, bus0.memUnsignedLoad);
    end
    // a second request waits while the first response is stalled
    bus0.reqValid   = 1'b1;
    bus0.reqOp      = 4'd4;
    bus0.reqAddress = 32'h0000_0040;
    bus0.reqData    = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus0.memDataIn = 32'h0000_0055;
      checks++;
      if ({bus0.respValid, bus0.respData, bus0.reqReady, bus0.memReadMode} !== {1'b1, 32'h0000_00AB, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b rmode=%0d expected 1 000000ab 0 0", i,
                 bus0.respValid, bus0.respData, bus0.reqReady, bus0.memReadMode);
      end
    end
    bus0.respReady = 1'b1;
    tick();
    checks++;
    if ({bus0.respValid, bus0.reqReady, bus0.memReadMode} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b rmode=%0d expected 0 1 0",
               bus0.respValid, bus0.reqReady, bus0.memReadMode);
    end
    tick();
    bus0.reqValid = 1'b0;
    checks++;
    if ({bus0.memReadMode, bus0.memAddress} !== {3'd3, 32'h0000_0040}) begin
      errors++;
      $display("FAIL bp_second: rmode=%0d addr=%h expected 3 00000040", bus0.memReadMode, bus0.memAddress);
    end
    tick();
    checks++;
    if ({bus0.respValid, bus0.respData} !== {1'b1, 32'h0000_0055}) begin
      errors++;
      $display("FAIL bp_second_resp: valid=%b data=%h expected 1 00000055", bus0.respValid, bus0.respData);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int count = 0;
    int first = -1;
    int last = -1;
    bus0.memDataIn  = 32'h0102_0304;
    bus0.reqValid   = 1'b1;
    bus0.reqOp      = 4'd4;
    bus0.reqAddress = 32'h0000_0010;
    bus0.reqData    = 32'h0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus0.respValid === 1'b1) begin
        count++;
        if (first < 0) first = i;
        last = i;
      end
    end
    bus0.reqValid = 1'b0;
    checks++;
    if (count != 3 || (last - first) != 6) begin
      errors++;
      $display("FAIL b2b_rate: responses=%0d span=%0d expected 3 6", count, last - first);
    end
    tick();
    tick();
  endtask

  task automatic test_wait_and_reset();
    logic bad;
    bus1.memDataIn = 32'h1234_5678;
    send1(4'd4, 32'h0000_0080, 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus1.memReadMode !== 3'd3 || bus1.respValid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL wait_hold: read mode not held 5 cycles, got flag %b expected 0", bad);
    end
    checks++;
    if ({bus1.respValid, bus1.respData, bus1.memReadMode} !== {1'b1, 32'h1234_5678, 3'd0}) begin
      errors++;
      $display("FAIL wait_resp: valid=%b data=%h rmode=%0d expected 1 12345678 0",
               bus1.respValid, bus1.respData, bus1.memReadMode);
    end
    tick();
    send1(4'd4, 32'h0000_0084, 32'h9);
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus1.respValid, bus1.respError, bus1.memReadMode, bus1.memWriteMode, bus1.memUnsignedLoad,
         bus1.memAddress, bus1.memData, bus1.respData, bus1.reqReady} !== {10'd0, 96'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_inflight: valid=%b rmode=%0d addr=%h data=%h ready=%b expected 0 0 0 0 1",
               bus1.respValid, bus1.memReadMode, bus1.memAddress, bus1.memData, bus1.reqReady);
    end
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus1.respValid !== 1'b0 || bus1.memReadMode !== 3'd0 || bus1.memWriteMode !== 3'd0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: activity after reset flag %b expected 0", bad);
    end
  endtask

  initial begin
    bus0.reqValid = 1'b0; bus0.reqOp = 4'd0; bus0.reqAddress = 32'd0; bus0.reqData = 32'd0;
    bus0.respReady = 1'b1; bus0.memDataIn = 32'd0;
    bus1.reqValid = 1'b0; bus1.reqOp = 4'd0; bus1.reqAddress = 32'd0; bus1.reqData = 32'd0;
    bus1.respReady = 1'b1; bus1.memDataIn = 32'd0;
    test_reset();
    test_lw();
    test_load_merge();
    test_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_wait_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
